// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map defaults, register offsets and responder FSM encodings.
package mem_map_pkg;
    localparam logic [31:0] MEM_BASE_DEF  = 32'h0080_0000;
    localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;
    localparam logic [31:0] OFS_CONSOLE   = 32'h0000_0000;
    localparam logic [31:0] OFS_CYCLES    = 32'h0000_0004;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_TX   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    typedef enum logic [1:0] {REG_RAM, REG_CONSOLE, REG_CYCLES, REG_NONE} region_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: native memory bus between the core (master) and the responder (slave).
interface mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
    modport slave  (input mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port RAM with byte write enables and registered read.
module mem_responder_ram #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: bus slave serving boot RAM, console TX and cycle counter registers.
// WAIT spans WAIT_STATES+1 cycles so the registered RAM read is ready before RESP.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF,
    parameter int          MEM_WORDS   = 4096,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF,
    parameter int          WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_ready,
    output logic           bus_error
);
    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_SPAN = 32'(4 * MEM_WORDS);
    logic [1:0]    state;
    logic [4:0]    cnt;
    logic [AW-1:0] ram_addr_q;
    logic [31:0]   wdata_q, cycles, cyc_q, ram_q, resp_data, word_addr;
    logic [3:0]    wstrb_q, ram_we;
    logic          in_ram, tx_go, wait_done, unused_ok;
    region_t       region, reg_q;
    assign word_addr = {bus.mem_addr[31:2], 2'b00};
    assign in_ram    = word_addr >= MEM_BASE && (word_addr - MEM_BASE) < MEM_SPAN;
    assign region    = in_ram ? REG_RAM :
                       word_addr == MMIO_BASE + OFS_CONSOLE ? REG_CONSOLE :
                       word_addr == MMIO_BASE + OFS_CYCLES ? REG_CYCLES : REG_NONE;
    assign tx_go     = reg_q == REG_CONSOLE && wstrb_q[0];
    // TX leaves WAIT one cycle early so tx_valid rises at k+WAIT_STATES+1
    assign wait_done = cnt == (tx_go ? 5'(WAIT_STATES) : 5'(WAIT_STATES + 1));
    assign ram_we    = (state == S_WAIT && wait_done && reg_q == REG_RAM) ? wstrb_q : 4'b0000;
    assign resp_data = reg_q == REG_RAM ? ram_q :
                       reg_q == REG_CONSOLE ? {31'b0, tx_ready} :
                       reg_q == REG_CYCLES ? cyc_q : 32'h0;
    assign unused_ok = ^{bus.mem_instr, bus.mem_addr[1:0]};
    mem_responder_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
        .clk  (clk),
        .addr (ram_addr_q),
        .we   (ram_we),
        .wdata(wdata_q),
        .rdata(ram_q)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            ram_addr_q    <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            reg_q         <= REG_NONE;
            cyc_q         <= '0;
            cycles        <= '0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            bus_error     <= 1'b0;
        end else begin
            cycles        <= cycles + 32'd1;
            bus.mem_ready <= 1'b0;
            case (state)
                S_IDLE: if (bus.mem_valid) begin
                    state      <= S_WAIT;
                    cnt        <= '0;
                    ram_addr_q <= bus.mem_addr[AW+1:2];
                    wdata_q    <= bus.mem_wdata;
                    wstrb_q    <= bus.mem_wstrb;
                    reg_q      <= region;
                    cyc_q      <= cycles;
                end
                S_WAIT: if (!wait_done) begin
                    cnt <= cnt + 5'd1;
                end else if (tx_go) begin
                    state    <= S_TX;
                    tx_valid <= 1'b1;
                    tx_data  <= wdata_q[7:0];
                end else begin
                    state         <= S_RESP;
                    bus.mem_ready <= 1'b1;
                    bus.mem_rdata <= resp_data;
                    bus_error     <= bus_error | (reg_q == REG_NONE);
                end
                S_TX: if (tx_ready) begin
                    state         <= S_RESP;
                    tx_valid      <= 1'b0;
                    bus.mem_ready <= 1'b1;
                    bus.mem_rdata <= resp_data;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of RAM, console, cycle counter, unmapped and reset behaviour.
module tb_mem_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid, tx_ready, bus_error;
    logic [7:0] tx_data;
    int         pass_cnt = 0;
    int         total = 0;
    mem_responder_if bus();
    mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .bus_error(bus_error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int lat);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.mem_ready && lat < 40);
        rd = bus.mem_rdata;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(negedge clk);
        chk("ready_width", {31'b0, bus.mem_ready}, 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] rd, c1, c2;
        int lat;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        tx_ready      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
        reset = 1'b0;
        // RAM full-word write and readback, latency k+3
        txn(32'h0080_0010, 32'hDEAD_BEEF, 4'b1111, rd, lat);
        chk("wr_latency", lat, 4);
        txn(32'h0080_0010, 32'h0, 4'b0000, rd, lat);
        chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
        chk("rd_latency", lat, 4);
        // byte-lane merge
        txn(32'h0080_0020, 32'h1122_3344, 4'b1111, rd, lat);
        txn(32'h0080_0020, 32'h0000_AA00, 4'b0010, rd, lat);
        txn(32'h0080_0020, 32'h0, 4'b0000, rd, lat);
        chk("partial_wr", rd, 32'h1122_AA44);
        // last RAM word and low-order address bits ignored
        txn(32'h0080_3FFC, 32'hCAFE_F00D, 4'b1111, rd, lat);
        txn(32'h0080_3FFF, 32'h0, 4'b0000, rd, lat);
        chk("top_word", rd, 32'hCAFE_F00D);
        txn(32'h0080_0000, 32'hA5A5_A5A5, 4'b1111, rd, lat);
        chk("bus_error_clear", {31'b0, bus_error}, 32'd0);
        // unmapped read
        txn(32'h2000_0000, 32'h0, 4'b0000, rd, lat);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_latency", lat, 4);
        chk("bus_error_set", {31'b0, bus_error}, 32'd1);
        // one past RAM end is unmapped and must not alias word 0
        txn(32'h0080_4000, 32'h1234_5678, 4'b1111, rd, lat);
        txn(32'h0080_0000, 32'h0, 4'b0000, rd, lat);
        chk("no_alias", rd, 32'hA5A5_A5A5);
        // console status reads
        tx_ready = 1'b1;
        txn(32'h1000_0000, 32'h0, 4'b0000, rd, lat);
        chk("console_rd_ready", rd, 32'd1);
        tx_ready = 1'b0;
        txn(32'h1000_0000, 32'h0, 4'b0000, rd, lat);
        chk("console_rd_busy", rd, 32'd0);
        // console write without lane 0: no TX, normal latency
        txn(32'h1000_0000, 32'h0000_4100, 4'b0010, rd, lat);
        chk("console_nolane_latency", lat, 4);
        chk("console_nolane_tx", {31'b0, tx_valid}, 32'd0);
        // console TX handshake with 5 stalled cycles
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h1000_0000;
        bus.mem_wdata = 32'h0000_0041;
        bus.mem_wstrb = 4'b1111;
        repeat (2) @(negedge clk);
        chk("tx_not_early", {31'b0, tx_valid}, 32'd0);
        @(negedge clk);
        chk("tx_valid_rise", {31'b0, tx_valid}, 32'd1);
        chk("tx_data", {24'b0, tx_data}, 32'h41);
        repeat (5) @(negedge clk);
        chk("tx_held", {31'b0, tx_valid}, 32'd1);
        chk("tx_stall_ready", {31'b0, bus.mem_ready}, 32'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("tx_drop", {31'b0, tx_valid}, 32'd0);
        chk("tx_ack", {31'b0, bus.mem_ready}, 32'd1);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        tx_ready = 1'b0;
        @(negedge clk);
        chk("tx_ack_width", {31'b0, bus.mem_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("tx_no_second", {31'b0, tx_valid}, 32'd0);
        chk("bus_error_sticky", {31'b0, bus_error}, 32'd1);
        // cycle counter spacing: accept edges 10 cycles apart
        txn(32'h1000_0004, 32'h0, 4'b0000, c1, lat);
        repeat (5) @(negedge clk);
        txn(32'h1000_0004, 32'h0, 4'b0000, c2, lat);
        chk("cycles_delta", c2 - c1, 32'd10);
        chk("cycles_latency", lat, 4);
        // cycle counter wrap
        force dut.cycles = 32'hFFFF_FFF8;
        @(negedge clk);
        release dut.cycles;
        repeat (10) @(negedge clk);
        txn(32'h1000_0004, 32'h0, 4'b0000, rd, lat);
        chk("cycles_wrap", rd, 32'd2);
        // reset during WAIT of a RAM write
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0080_0010;
        bus.mem_wdata = 32'h5555_5555;
        bus.mem_wstrb = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_wait_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("rst_wait_bus_error", {31'b0, bus_error}, 32'd0);
        chk("rst_wait_rdata", bus.mem_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        repeat (3) @(negedge clk);
        txn(32'h1000_0004, 32'h0, 4'b0000, rd, lat);
        chk("cycles_after_reset", rd, 32'd3);
        txn(32'h0080_0010, 32'h0, 4'b0000, rd, lat);
        chk("rst_wait_no_commit", rd, 32'hDEAD_BEEF);
        chk("rst_wait_recover_latency", lat, 4);
        // reset during TX
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h1000_0000;
        bus.mem_wdata = 32'h0000_0042;
        bus.mem_wstrb = 4'b0001;
        repeat (4) @(negedge clk);
        chk("tx2_valid", {31'b0, tx_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_tx_valid_drop", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_data_clear", {24'b0, tx_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_tx_idle", {31'b0, tx_valid}, 32'd0);
        txn(32'h0080_0020, 32'h0, 4'b0000, rd, lat);
        chk("rst_tx_recover", rd, 32'h1122_AA44);
        chk("rst_tx_recover_latency", lat, 4);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
